param_datapath: RTL and testbench
=================================

// Module: param_datapath
// PURPOSE
//  Parametrised bus-based CPU datapath: register file, PC, IR, MAR, MDR, HI/LO, Y, 2xW Z, shared one-hot-selected bus.
//  Generalises the fixed 32-bit/16-register datapath in width and register count.
//  Adds a multi-cycle signed MUL/DIV sequencer, bus-conflict detection and a configurable hard-wired-zero R0.
//  Sits between the control unit (drives all strobes) and the memory subsystem (MAR/MDR).
// PARAMETERS
//  DATA_W    32  datapath width in bits; must be a power of two, >= 8
//  NUM_REGS  16  general-purpose registers R0..R(NUM_REGS-1)
//  R0_ZERO   1   1: R0 drives 0 onto the bus whatever it stores; 0: normal register
//  PC_STEP   1   amount added to PC by inc_pc
// PORTS
//  clock        in   1          rising-edge clock
//  clear        in   1          asynchronous reset, active-low
//  reg_in       in   NUM_REGS   one-hot load strobes, GPRs
//  reg_out      in   NUM_REGS   bus-drive enables, GPRs
//  pc_in/pc_out in   1          PC load / drive
//  inc_pc       in   1          PC <= PC + PC_STEP
//  ir_in        in   1          IR load
//  mar_in       in   1          MAR load
//  mdr_in       in   1          MDR load
//  mdr_read     in   1          MDR source: 1 = mem_data_in, 0 = bus
//  mdr_out      in   1          MDR drive
//  hi_in/hi_out in   1          HI load / drive
//  lo_in/lo_out in   1          LO load / drive
//  y_in         in   1          Y load (ALU operand A)
//  z_in         in   1          Z load from a single-cycle ALU op
//  zhigh_out    in   1          drive Z[2W-1:W]
//  zlow_out     in   1          drive Z[W-1:0]
//  alu_op       in   4          0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHRA,6 SHL,7 ROR,8 ROL,9 NEG,10 NOT,11 MUL,12 DIV
//  alu_start    in   1          start a MUL/DIV (alu_op 11/12 only)
//  mem_data_in  in   DATA_W     memory read data into MDR
//  bus_value    out  DATA_W     current bus value
//  ir_value     out  DATA_W     IR contents
//  mar_value    out  DATA_W     MAR contents (memory address)
//  mdr_value    out  DATA_W     MDR contents (memory write data)
//  alu_busy     out  1          MUL/DIV sequencer running
//  alu_done     out  1          one-cycle pulse: MUL/DIV result written to Z
//  div_by_zero  out  1          last DIV had a zero divisor; held until the next alu_start
//  bus_conflict out  1          combinational: more than one bus-drive enable asserted
// BEHAVIOUR
//  - Reset (clear=0, async): every register, Z, sequencer state and every registered output go to 0.
//  - Bus, combinational: exactly one enable -> that source; none -> 0; >1 -> bus=0 and bus_conflict=1.
//    R0 with R0_ZERO=1 drives 0.
//  - Loads happen on the rising edge while the strobe is high. Several *_in strobes may be high together; all capture the same bus.
//  - PC: pc_in has priority over inc_pc. The increment wraps modulo 2^DATA_W.
//  - Single-cycle ops (0-10): A=Y, B=bus.
//    - Z <= {W'0, result} on the z_in edge. Add/sub wrap with no carry out.
//    - Shift/rotate amount is B[log2(DATA_W)-1:0].
//    - NEG/NOT act on B.
//    - z_in with op 11/12 does not load Z.
//  - Sequencer FSM: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE: alu_start=1 with op 11/12 latches A=Y, B=bus and the op, then enters RUN. A start with any other op is ignored.
//    - RUN: one iteration per cycle for exactly DATA_W cycles; alu_busy=1.
//    - DONE: Z is written; alu_done=1 for that single cycle. Result is visible in Z DATA_W+1 edges after the start edge.
//    - MUL: signed W x W -> 2W product; Z = {high, low}.
//    - DIV: signed; quotient truncates toward zero into Z low; remainder, with the dividend's sign, into Z high.
//    - DIV with B=0: Z = {A, all-ones}, div_by_zero=1, same latency.
//    - alu_start and z_in are ignored while in RUN/DONE. Z holds its value until the DONE write.
//    - The most-negative / -1 DIV gives quotient = most-negative, remainder = 0.
//  - Reset mid-operation aborts the sequencer to IDLE with Z=0 and no alu_done pulse.
// TESTING
//  - Y=7, bus=R1=5, ADD, z_in, then zlow_out -> bus=12; zhigh_out -> bus=0.
//  - reg_out[1] and reg_out[2] both high -> bus=0, bus_conflict=1. With R0_ZERO=1, R0 loaded with 9 then driven -> bus=0.
//  - Y=-3, bus=6, MUL start -> alu_busy for 32 cycles; at cycle 33 Z=64'hFFFFFFFF_FFFFFFEE, alu_done for 1 cycle.
//  - Y=-7, bus=2, DIV -> Z low=-3, Z high=-1. Y=5, bus=0, DIV -> Z={5,32'hFFFFFFFF}, div_by_zero=1.
//  - PC=32'hFFFFFFFF, inc_pc -> 0. pc_in and inc_pc together with bus=0x40 -> PC=0x40.
//  - Assert clear 10 cycles into a MUL -> alu_busy=0, Z=0 immediately; no alu_done afterwards.

Source files
------------

// File: rtl/param_datapath.sv
// Bus-based CPU datapath: register file, PC/IR/MAR/MDR/HI/LO/Y, a 2xW Z register and
// a multi-cycle signed MUL/DIV sequencer sharing one one-hot-selected bus.
module param_datapath #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter bit R0_ZERO  = 1'b1,
    parameter int PC_STEP  = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [NUM_REGS-1:0] reg_in,
    input  logic [NUM_REGS-1:0] reg_out,
    input  logic                pc_in,
    input  logic                pc_out,
    input  logic                inc_pc,
    input  logic                ir_in,
    input  logic                mar_in,
    input  logic                mdr_in,
    input  logic                mdr_read,
    input  logic                mdr_out,
    input  logic                hi_in,
    input  logic                hi_out,
    input  logic                lo_in,
    input  logic                lo_out,
    input  logic                y_in,
    input  logic                z_in,
    input  logic                zhigh_out,
    input  logic                zlow_out,
    input  logic [3:0]          alu_op,
    input  logic                alu_start,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic [DATA_W-1:0]   bus_value,
    output logic [DATA_W-1:0]   ir_value,
    output logic [DATA_W-1:0]   mar_value,
    output logic [DATA_W-1:0]   mdr_value,
    output logic                alu_busy,
    output logic                alu_done,
    output logic                div_by_zero,
    output logic                bus_conflict
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [2*DATA_W-1:0] z_q, z_d;

    seq_state_t          state_q, state_d;
    logic [SH_W-1:0]     cnt_q, cnt_d;
    logic                is_div_q, is_div_d, b_neg_q, b_neg_d, dbz_q, dbz_d;
    logic [DATA_W-1:0]   a_q, a_d, mag_q, mag_d, lo_w_q, lo_w_d;
    logic [DATA_W:0]     hi_w_q, hi_w_d;

    logic [DATA_W-1:0]   bus, bus_or, alu_res;
    logic                seen_drv, multi_drv;
    logic [5:0]          misc_en;
    logic [DATA_W-1:0]   misc_val [6];

    function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    assign misc_en     = {pc_out, mdr_out, hi_out, lo_out, zhigh_out, zlow_out};
    assign misc_val[0] = z_q[DATA_W-1:0];
    assign misc_val[1] = z_q[2*DATA_W-1:DATA_W];
    assign misc_val[2] = lo_q;
    assign misc_val[3] = hi_q;
    assign misc_val[4] = mdr_q;
    assign misc_val[5] = pc_q;

    // A second enable forces the bus to zero rather than OR-ing the sources together.
    always_comb begin
        bus_or    = '0;
        seen_drv  = 1'b0;
        multi_drv = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_out[i]) begin
                multi_drv = multi_drv | seen_drv;
                seen_drv  = 1'b1;
                if (!(R0_ZERO && i == 0)) bus_or = bus_or | regs_q[i];
            end
        end
        for (int j = 0; j < 6; j++) begin
            if (misc_en[j]) begin
                multi_drv = multi_drv | seen_drv;
                seen_drv  = 1'b1;
                bus_or    = bus_or | misc_val[j];
            end
        end
        bus = multi_drv ? '0 : bus_or;
    end

    always_comb begin
        logic [SH_W-1:0]     amt;
        logic [2*DATA_W-1:0] rot;
        amt     = bus[SH_W-1:0];
        rot     = '0;
        alu_res = '0;
        case (alu_op)
            4'd0:  alu_res = y_q + bus;
            4'd1:  alu_res = y_q - bus;
            4'd2:  alu_res = y_q & bus;
            4'd3:  alu_res = y_q | bus;
            4'd4:  alu_res = y_q >> amt;
            4'd5:  alu_res = $unsigned($signed(y_q) >>> amt);
            4'd6:  alu_res = y_q << amt;
            4'd7:  begin rot = {y_q, y_q} >> amt; alu_res = rot[DATA_W-1:0]; end
            4'd8:  begin rot = {y_q, y_q} << amt; alu_res = rot[2*DATA_W-1:DATA_W]; end
            4'd9:  alu_res = -bus;
            4'd10: alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_in[i] ? bus : regs_q[i];
        pc_d  = pc_in ? bus : (inc_pc ? pc_q + DATA_W'(PC_STEP) : pc_q);
        ir_d  = ir_in  ? bus : ir_q;
        mar_d = mar_in ? bus : mar_q;
        mdr_d = mdr_in ? (mdr_read ? mem_data_in : bus) : mdr_q;
        hi_d  = hi_in  ? bus : hi_q;
        lo_d  = lo_in  ? bus : lo_q;
        y_d   = y_in   ? bus : y_q;
    end

    // Magnitudes are iterated unsigned (shift-add / restoring divide); signs are applied in DONE.
    always_comb begin
        logic [DATA_W:0]     sum, shifted;
        logic [DATA_W+1:0]   diff;
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   quo, rem;
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        b_neg_d  = b_neg_q;
        dbz_d    = dbz_q;
        a_d      = a_q;
        mag_d    = mag_q;
        hi_w_d   = hi_w_q;
        lo_w_d   = lo_w_q;
        z_d      = z_q;
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        prod     = '0;
        quo      = '0;
        rem      = '0;
        case (state_q)
            IDLE: begin
                if (alu_start && (alu_op == OP_MUL || alu_op == OP_DIV)) begin
                    is_div_d = (alu_op == OP_DIV);
                    a_d      = y_q;
                    b_neg_d  = bus[DATA_W-1];
                    mag_d    = (alu_op == OP_DIV) ? mag_of(bus) : mag_of(y_q);
                    lo_w_d   = (alu_op == OP_DIV) ? mag_of(y_q) : mag_of(bus);
                    hi_w_d   = '0;
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    state_d  = RUN;
                end else if (z_in && alu_op != OP_MUL && alu_op != OP_DIV) begin
                    z_d = {{DATA_W{1'b0}}, alu_res};
                end
            end
            RUN: begin
                if (is_div_q) begin
                    shifted = {hi_w_q[DATA_W-1:0], lo_w_q[DATA_W-1]};
                    diff    = {1'b0, shifted} - {2'b00, mag_q};
                    if (!diff[DATA_W+1]) begin
                        hi_w_d = diff[DATA_W:0];
                        lo_w_d = {lo_w_q[DATA_W-2:0], 1'b1};
                    end else begin
                        hi_w_d = shifted;
                        lo_w_d = {lo_w_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    sum    = hi_w_q + (lo_w_q[0] ? {1'b0, mag_q} : '0);
                    hi_w_d = {1'b0, sum[DATA_W:1]};
                    lo_w_d = {sum[0], lo_w_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + SH_W'(1);
                if (cnt_q == SH_W'(DATA_W - 1)) state_d = DONE;
            end
            DONE: begin
                if (is_div_q && mag_q == '0) begin
                    z_d   = {a_q, {DATA_W{1'b1}}};
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    quo = (a_q[DATA_W-1] ^ b_neg_q) ? -lo_w_q : lo_w_q;
                    rem = a_q[DATA_W-1] ? -hi_w_q[DATA_W-1:0] : hi_w_q[DATA_W-1:0];
                    z_d = {rem, quo};
                end else begin
                    prod = {hi_w_q[DATA_W-1:0], lo_w_q};
                    z_d  = (a_q[DATA_W-1] ^ b_neg_q) ? -prod : prod;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            z_q      <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            b_neg_q  <= 1'b0;
            dbz_q    <= 1'b0;
            a_q      <= '0;
            mag_q    <= '0;
            hi_w_q   <= '0;
            lo_w_q   <= '0;
        end else begin
            regs_q   <= regs_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            z_q      <= z_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            b_neg_q  <= b_neg_d;
            dbz_q    <= dbz_d;
            a_q      <= a_d;
            mag_q    <= mag_d;
            hi_w_q   <= hi_w_d;
            lo_w_q   <= lo_w_d;
        end
    end

    assign bus_value    = bus;
    assign ir_value     = ir_q;
    assign mar_value    = mar_q;
    assign mdr_value    = mdr_q;
    assign alu_busy     = (state_q == RUN);
    assign alu_done     = (state_q == DONE);
    assign div_by_zero  = dbz_q;
    assign bus_conflict = multi_drv;

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath at the default 32-bit / 16-register configuration.
module tb_param_datapath;
    localparam int W  = 32;
    localparam int NR = 16;

    logic          clock = 1'b0;
    logic          clear;
    logic [NR-1:0] reg_in, reg_out;
    logic          pc_in, pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_read, mdr_out;
    logic          hi_in, hi_out, lo_in, lo_out, y_in, z_in, zhigh_out, zlow_out;
    logic [3:0]    alu_op;
    logic          alu_start;
    logic [W-1:0]  mem_data_in;
    logic [W-1:0]  bus_value, ir_value, mar_value, mdr_value;
    logic          alu_busy, alu_done, div_by_zero, bus_conflict;

    int            vectors = 0;
    int            miscompares = 0;
    logic [2*W-1:0] sb_q [$];

    param_datapath #(.DATA_W(W), .NUM_REGS(NR), .R0_ZERO(1'b1), .PC_STEP(1)) dut (
        .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
        .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .ir_in(ir_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_read(mdr_read), .mdr_out(mdr_out),
        .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
        .y_in(y_in), .z_in(z_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .alu_op(alu_op), .alu_start(alu_start), .mem_data_in(mem_data_in),
        .bus_value(bus_value), .ir_value(ir_value), .mar_value(mar_value), .mdr_value(mdr_value),
        .alu_busy(alu_busy), .alu_done(alu_done), .div_by_zero(div_by_zero),
        .bus_conflict(bus_conflict)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a >> s;
            4'd5:  return $unsigned($signed(a) >>> s);
            4'd6:  return a << s;
            4'd7:  return (a >> s) | (a << (W - s));
            4'd8:  return (a << s) | (a >> (W - s));
            4'd9:  return 32'd0 - b;
            4'd10: return ~b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2*W-1:0] muldiv_model(input logic is_div, input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic signed [63:0] la, lb, q, r;
        la = 64'($signed(a));
        lb = 64'($signed(b));
        if (!is_div) return la * lb;
        if (b == '0) return {a, {W{1'b1}}};
        q = la / lb;
        r = la % lb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drop_strobes();
        reg_in = '0; reg_out = '0;
        pc_in = 0; pc_out = 0; inc_pc = 0; ir_in = 0; mar_in = 0; mdr_in = 0; mdr_read = 0;
        mdr_out = 0; hi_in = 0; hi_out = 0; lo_in = 0; lo_out = 0; y_in = 0; z_in = 0;
        zhigh_out = 0; zlow_out = 0; alu_start = 0;
    endtask

    task automatic put_mdr(input logic [W-1:0] v);
        mem_data_in = v; mdr_read = 1; mdr_in = 1;
        tick();
        mdr_in = 0; mdr_read = 0;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        put_mdr(v);
        mdr_out = 1; y_in = 1;
        tick();
        mdr_out = 0; y_in = 0;
    endtask

    task automatic set_reg(input int idx, input logic [W-1:0] v);
        put_mdr(v);
        mdr_out = 1; reg_in[idx] = 1'b1;
        tick();
        mdr_out = 0; reg_in = '0;
    endtask

    task automatic read_z(output logic [2*W-1:0] z);
        zhigh_out = 1; #1; z[2*W-1:W] = bus_value; zhigh_out = 0;
        zlow_out = 1;  #1; z[W-1:0]   = bus_value; zlow_out = 0;
        #1;
    endtask

    task automatic test_reset();
        clear = 0;
        drop_strobes();
        alu_op = '0; mem_data_in = '0;
        #3;
        vectors++; if (bus_value !== '0) begin miscompares++; $display("[TB] FAIL reset_bus: got %h expected 0", bus_value); end
        vectors++; if (ir_value !== '0 || mar_value !== '0 || mdr_value !== '0) begin
            miscompares++; $display("[TB] FAIL reset_regs: got ir=%h mar=%h mdr=%h expected 0", ir_value, mar_value, mdr_value); end
        vectors++; if ({alu_busy, alu_done, div_by_zero, bus_conflict} !== 4'b0) begin
            miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000", {alu_busy, alu_done, div_by_zero, bus_conflict}); end
        tick(); tick();
        clear = 1;
        tick();
    endtask

    task automatic test_add();
        logic [2*W-1:0] z, exp;
        set_reg(1, 32'd5);
        set_y(32'd7);
        sb_q.push_back(64'd12);
        reg_out[1] = 1; alu_op = 4'd0; z_in = 1;
        tick();
        reg_out = '0; z_in = 0;
        read_z(z);
        exp = sb_q.pop_front();
        vectors++; if (z[W-1:0] !== exp[W-1:0]) begin miscompares++; $display("[TB] FAIL add_zlow: got %h expected %h", z[W-1:0], exp[W-1:0]); end
        vectors++; if (z[2*W-1:W] !== exp[2*W-1:W]) begin miscompares++; $display("[TB] FAIL add_zhigh: got %h expected %h", z[2*W-1:W], exp[2*W-1:W]); end
    endtask

    task automatic test_bus_conflict();
        set_reg(1, 32'h1111_1111);
        set_reg(2, 32'h2222_2222);
        reg_out[1] = 1; reg_out[2] = 1; #1;
        vectors++; if (bus_value !== '0 || bus_conflict !== 1'b1) begin
            miscompares++; $display("[TB] FAIL conflict_r1r2: got bus=%h c=%b expected 0 1", bus_value, bus_conflict); end
        reg_out[2] = 0; #1;
        vectors++; if (bus_value !== 32'h1111_1111 || bus_conflict !== 1'b0) begin
            miscompares++; $display("[TB] FAIL single_r1: got bus=%h c=%b expected 11111111 0", bus_value, bus_conflict); end
        reg_out = '0; pc_out = 1; mdr_out = 1; #1;
        vectors++; if (bus_conflict !== 1'b1 || bus_value !== '0) begin
            miscompares++; $display("[TB] FAIL conflict_pc_mdr: got bus=%h c=%b expected 0 1", bus_value, bus_conflict); end
        pc_out = 0; mdr_out = 0;
        set_reg(0, 32'd9);
        reg_out[0] = 1; #1;
        vectors++; if (bus_value !== '0 || bus_conflict !== 1'b0) begin
            miscompares++; $display("[TB] FAIL r0_zero: got bus=%h c=%b expected 0 0", bus_value, bus_conflict); end
        reg_out = '0; #1;
        vectors++; if (bus_value !== '0) begin miscompares++; $display("[TB] FAIL idle_bus: got %h expected 0", bus_value); end
    endtask

    task automatic test_alu_ops();
        logic [W-1:0]   av [3];
        logic [W-1:0]   bv [3];
        logic [2*W-1:0] z, exp;
        av[0] = 32'hF000_1234; bv[0] = 32'h0000_0005;
        av[1] = 32'h0000_00FF; bv[1] = 32'h8000_0003;
        av[2] = $urandom;      bv[2] = $urandom;
        for (int p = 0; p < 3; p++) begin
            for (int op = 0; op <= 10; op++) begin
                sb_q.push_back({{W{1'b0}}, alu_model(4'(op), av[p], bv[p])});
                set_y(av[p]);
                put_mdr(bv[p]);
                mdr_out = 1; alu_op = 4'(op); z_in = 1;
                tick();
                mdr_out = 0; z_in = 0;
                read_z(z);
                exp = sb_q.pop_front();
                vectors++; if (z !== exp) begin
                    miscompares++; $display("[TB] FAIL alu_op%0d: got %h expected %h (a=%h b=%h)", op, z, exp, av[p], bv[p]); end
            end
        end
        sb_q.push_back(z);
        put_mdr(32'h1234_5678);
        mdr_out = 1; alu_op = 4'd11; z_in = 1;
        tick();
        mdr_out = 0; z_in = 0;
        read_z(z);
        exp = sb_q.pop_front();
        vectors++; if (z !== exp) begin miscompares++; $display("[TB] FAIL zin_mul_ignored: got %h expected %h", z, exp); end
    endtask

    task automatic test_pc();
        put_mdr(32'hFFFF_FFFF);
        mdr_out = 1; pc_in = 1; tick(); mdr_out = 0; pc_in = 0;
        inc_pc = 1; tick(); inc_pc = 0;
        pc_out = 1; #1;
        vectors++; if (bus_value !== 32'h0) begin miscompares++; $display("[TB] FAIL pc_wrap: got %h expected 0", bus_value); end
        pc_out = 0;
        put_mdr(32'h40);
        mdr_out = 1; pc_in = 1; inc_pc = 1; tick(); mdr_out = 0; pc_in = 0;
        pc_out = 1; #1;
        vectors++; if (bus_value !== 32'h40) begin miscompares++; $display("[TB] FAIL pc_priority: got %h expected 40", bus_value); end
        pc_out = 0;
        tick();
        pc_out = 1; #1;
        vectors++; if (bus_value !== 32'h41) begin miscompares++; $display("[TB] FAIL pc_inc: got %h expected 41", bus_value); end
        pc_out = 0; inc_pc = 0;
    endtask

    task automatic test_regs();
        put_mdr(32'hCAFE_F00D);
        mdr_out = 1; ir_in = 1; mar_in = 1; hi_in = 1; lo_in = 1;
        tick();
        drop_strobes();
        vectors++; if (ir_value !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL ir_load: got %h expected cafef00d", ir_value); end
        vectors++; if (mar_value !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL mar_load: got %h expected cafef00d", mar_value); end
        hi_out = 1; #1;
        vectors++; if (bus_value !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL hi_load: got %h expected cafef00d", bus_value); end
        hi_out = 0; lo_out = 1; #1;
        vectors++; if (bus_value !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL lo_load: got %h expected cafef00d", bus_value); end
        lo_out = 0;
        set_reg(3, 32'h0BAD_BEEF);
        reg_out[3] = 1; mdr_in = 1; mdr_read = 0; mem_data_in = 32'h5555_5555;
        tick();
        drop_strobes();
        vectors++; if (mdr_value !== 32'h0BAD_BEEF) begin miscompares++; $display("[TB] FAIL mdr_from_bus: got %h expected 0badbeef", mdr_value); end
    endtask

    task automatic run_muldiv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit disturb);
        logic [2*W-1:0] z, exp;
        int             busy_cnt;
        bit             seen;
        sb_q.push_back(muldiv_model(op == 4'd12, a, b));
        set_y(a);
        put_mdr(b);
        mdr_out = 1; alu_op = op; alu_start = 1;
        tick();
        mdr_out = 0; alu_start = 0;
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL dbz_cleared: got %b expected 0", div_by_zero); end
        busy_cnt = 0;
        seen     = 0;
        for (int c = 0; c < W + 10; c++) begin
            if (alu_done) begin seen = 1; break; end
            if (alu_busy) busy_cnt++;
            if (disturb && c == 5) begin
                alu_start = 1; z_in = 1; alu_op = (op == 4'd11) ? 4'd12 : 4'd11; reg_out[1] = 1;
            end
            tick();
            alu_start = 0; z_in = 0; reg_out = '0;
        end
        vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL done_timeout: got none expected alu_done within %0d cycles", W + 10); end
        vectors++; if (busy_cnt != W) begin miscompares++; $display("[TB] FAIL busy_cycles: got %0d expected %0d", busy_cnt, W); end
        tick();
        vectors++; if (alu_done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_pulse: got %b expected 0", alu_done); end
        read_z(z);
        exp = sb_q.pop_front();
        vectors++; if (z !== exp) begin
            miscompares++; $display("[TB] FAIL muldiv_op%0d: got %h expected %h (a=%h b=%h)", op, z, exp, a, b); end
        vectors++; if (div_by_zero !== (op == 4'd12 && b == '0)) begin
            miscompares++; $display("[TB] FAIL dbz_flag: got %b expected %b", div_by_zero, (op == 4'd12 && b == '0)); end
    endtask

    task automatic test_mul_div();
        run_muldiv(4'd11, -32'sd3, 32'd6, 0);
        run_muldiv(4'd12, -32'sd7, 32'd2, 0);
        run_muldiv(4'd12, 32'd5, 32'd0, 0);
        tick(); tick(); tick();
        vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("[TB] FAIL dbz_held: got %b expected 1", div_by_zero); end
        run_muldiv(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_muldiv(4'd11, 32'h8000_0000, 32'h8000_0000, 0);
        run_muldiv(4'd11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        run_muldiv(4'd12, 32'd100, -32'sd7, 0);
        run_muldiv(4'd12, -32'sd100, -32'sd7, 0);
        run_muldiv(4'd11, $urandom, $urandom, 0);
        run_muldiv(4'd12, $urandom, $urandom_range(1, 1000), 0);
    endtask

    task automatic test_back_to_back();
        run_muldiv(4'd11, 32'd1234, -32'sd77, 1);
        run_muldiv(4'd12, -32'sd99999, 32'd321, 1);
        run_muldiv(4'd11, 32'hDEAD_BEEF, 32'h0000_1001, 0);
    endtask

    task automatic test_reset_abort();
        logic [2*W-1:0] z;
        int             done_seen;
        set_y(-32'sd3);
        put_mdr(32'd6);
        mdr_out = 1; alu_op = 4'd11; alu_start = 1;
        tick();
        mdr_out = 0; alu_start = 0;
        for (int c = 0; c < 10; c++) tick();
        clear = 0; #1;
        vectors++; if (alu_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", alu_busy); end
        clear = 1;
        read_z(z);
        vectors++; if (z !== '0) begin miscompares++; $display("[TB] FAIL abort_z: got %h expected 0", z); end
        done_seen = 0;
        for (int c = 0; c < W + 5; c++) begin
            if (alu_done || alu_busy) done_seen++;
            tick();
        end
        vectors++; if (done_seen != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bus_conflict();
        test_alu_ops();
        test_pc();
        test_regs();
        test_mul_div();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
